pad_input_filter: RTL and testbench
===================================

# pad_input_filter

Multi-channel input conditioning stage that sits directly downstream of the pad Schmitt buffers, consuming their `X` outputs. Asynchronous pad levels pass through a 2-flop synchroniser, a per-channel debounce counter, edge detection and a sticky interrupt pending register. The debounced levels and edge pulses feed the housekeeping/GPIO logic on the Wishbone clock domain.

## Interface
- `NCH`, 4, number of pad channels
- `CNT_W`, 8, debounce counter / threshold width
- `wb_clk_i`  in  1  single clock for all state
- `wb_rst_i`  in  1  reset, synchronous, active-high
- `pad_x_i`  in  NCH  asynchronous Schmitt buffer outputs
- `filt_en_i`  in  1  1: debounce active; 0: bypass (threshold forced to 1)
- `db_thresh_i`  in  CNT_W  stable cycles required before level change; 0 treated as 1
- `irq_mask_i`  in  NCH  per-channel interrupt enable, both edges
- `irq_clr_i`  in  1  one-cycle pulse clearing all pending bits
- `level_o`  out  NCH  debounced level, registered
- `rise_o`  out  NCH  one-cycle pulse, registered
- `fall_o`  out  NCH  one-cycle pulse, registered
- `pend_o`  out  NCH  sticky pending bits
- `irq_o`  out  1  OR of `pend_o`, registered
- `evt_cnt_o`  out  16  rising-edge event count (only with `PAD_FILT_EVTCNT_EN`)
- `evt_clr_i`  in  1  clears `evt_cnt_o` (only with `PAD_FILT_EVTCNT_EN`)

## Operation
- Reset: `sync1`, `sync2`, `cnt`, `level_o`, `rise_o`, `fall_o`, `pend_o`, `irq_o`, `evt_cnt_o` all 0.
- Sync: `sync1 <= pad_x_i`, `sync2 <= sync1`; no other logic touches `pad_x_i`.
- Effective threshold `T` = 1 if `filt_en_i`=0 or `db_thresh_i`=0, else `db_thresh_i`.
- Per channel, per cycle:
  - `sync2 == level`: `cnt <= 0`.
  - `sync2 != level` and `cnt + 1 >= T`: `level <= sync2`, `cnt <= 0`, pulse `rise`/`fall` as appropriate.
  - otherwise `cnt <= cnt + 1`, saturating at all-ones.
- Any glitch returning `sync2` to `level` before `T` cycles restarts the count; no edge is produced.
- `>=` compare: lowering `db_thresh_i` mid-count flips on the next cycle if already satisfied; raising it extends the wait.
- `rise_o`/`fall_o` are high exactly one cycle, coincident with the first cycle `level_o` shows the new value.
- Pending: `pend[i] <= (pend[i] & ~irq_clr_i) | ((rise[i]|fall[i]) & irq_mask_i[i])`, evaluated on the next-state edge, so set wins over a simultaneous clear. `irq_o <= |pend_next`.
- Mask change does not clear existing pending bits.
- Reset mid-operation: all state clears the same edge. A pad held high through reset yields a fresh `rise_o` at `2+T` cycles after reset release.

## Timing
- Pad change sampled at edge 0 → `sync2` at edge 1 → `level_o`/`rise_o` at edge `1+T`. Minimum latency with `T`=1 is 2 cycles.
- `pend_o` and `irq_o` update 1 cycle after the edge pulse, so `irq_o` is at edge `2+T`.
- Continuous toggling faster than `T` cycles never changes `level_o`.

## Configuration
- `PAD_FILT_EVTCNT_EN` defined:
  - 16-bit `evt_cnt_o` adds the popcount of `rise_o` each cycle, saturating at 0xFFFF.
  - `evt_clr_i` zeroes it; a simultaneous increment is dropped in favour of the clear.
- Undefined: `evt_cnt_o` and `evt_clr_i` ports are absent, and no counter logic is generated.

## Test plan
- Reset, `T`=4, ch0 pad 0→1 held → `level_o[0]`=1 and `rise_o[0]` pulse at edge 5; `irq_o`=1 at edge 6 with `irq_mask_i`=4'b0001.
- `T`=4, ch1 glitch high for 3 cycles then low → no `rise_o[1]`, `level_o[1]` stays 0, `cnt` returns to 0.
- `filt_en_i`=0, `db_thresh_i`=200, ch2 toggles every 2 cycles → `level_o[2]` follows with 2-cycle latency and a pulse on each edge.
- ch3 edge pulse in the same cycle as `irq_clr_i` with `pend_o`=4'b0001 → `pend_o`=4'b1000, `irq_o` stays 1.
- Pad held high, assert `wb_rst_i` 3 cycles mid-count → all outputs 0; `rise_o` reappears `2+T` cycles after release.
- With `PAD_FILT_EVTCNT_EN`: 3 channels rise in the same cycle → `evt_cnt_o`+=3. Preload to 0xFFFE plus 3 rises → 0xFFFF. `evt_clr_i` together with a rise → 0.

Source files
------------

// File: rtl/pad_input_filter.sv
// pad_input_filter
//
// Input conditioning for the pad Schmitt buffer outputs. Each channel goes
// through a 2-flop synchroniser, a debounce counter, edge detection and a
// sticky interrupt pending register. Everything runs on wb_clk_i.
//
// Optional feature macro: PAD_FILT_EVTCNT_EN
//   When defined, a 16-bit saturating rising-edge event counter is added
//   together with the evt_cnt_o / evt_clr_i ports. When undefined those ports
//   and all counter logic are absent.
//
// Ports:
//   wb_clk_i     clock for all state
//   wb_rst_i     synchronous active-high reset
//   pad_x_i      asynchronous pad levels, one bit per channel
//   filt_en_i    1: debounce active, 0: bypass (threshold of 1)
//   db_thresh_i  stable cycles needed before a level change (0 acts as 1)
//   irq_mask_i   per-channel interrupt enable (both edges)
//   irq_clr_i    single-cycle pulse clearing all pending bits
//   level_o      debounced level
//   rise_o       single-cycle pulse on a debounced rising edge
//   fall_o       single-cycle pulse on a debounced falling edge
//   pend_o       sticky pending bits
//   irq_o        OR of the pending bits
//   evt_cnt_o    rising-edge event count (PAD_FILT_EVTCNT_EN only)
//   evt_clr_i    clears evt_cnt_o (PAD_FILT_EVTCNT_EN only)

module pad_input_filter #(
  parameter int NCH   = 4,
  parameter int CNT_W = 8
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic [NCH-1:0]   pad_x_i,
  input  logic             filt_en_i,
  input  logic [CNT_W-1:0] db_thresh_i,
  input  logic [NCH-1:0]   irq_mask_i,
  input  logic             irq_clr_i,
  output logic [NCH-1:0]   level_o,
  output logic [NCH-1:0]   rise_o,
  output logic [NCH-1:0]   fall_o,
  output logic [NCH-1:0]   pend_o,
  output logic             irq_o
`ifdef PAD_FILT_EVTCNT_EN
  ,
  output logic [15:0]      evt_cnt_o,
  input  logic             evt_clr_i
`endif
);

  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W:0]   INC_ONE = 1;

  logic [NCH-1:0]   sync1;
  logic [NCH-1:0]   sync2;
  logic [CNT_W-1:0] cnt      [NCH];
  logic [CNT_W-1:0] cnt_next [NCH];
  logic [CNT_W:0]   cnt_inc  [NCH];
  logic [CNT_W-1:0] thresh_eff;
  logic [NCH-1:0]   level_next;
  logic [NCH-1:0]   rise_next;
  logic [NCH-1:0]   fall_next;
  logic [NCH-1:0]   pend_next;

  // A zero threshold or bypass mode both mean "accept on the first differing
  // cycle", so they collapse to a threshold of one.
  always_comb begin
    thresh_eff = db_thresh_i;
    if (!filt_en_i || (db_thresh_i == '0)) begin
      thresh_eff = CNT_ONE;
    end
  end

  // Debounce and edge decision per channel. The increment is done one bit
  // wider so the >= compare stays correct when the counter is at all-ones.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      cnt_inc[i]    = {1'b0, cnt[i]} + INC_ONE;
      cnt_next[i]   = cnt[i];
      level_next[i] = level_o[i];
      rise_next[i]  = 1'b0;
      fall_next[i]  = 1'b0;
      if (sync2[i] == level_o[i]) begin
        cnt_next[i] = '0;
      end else if (cnt_inc[i] >= {1'b0, thresh_eff}) begin
        level_next[i] = sync2[i];
        cnt_next[i]   = '0;
        rise_next[i]  = sync2[i];
        fall_next[i]  = ~sync2[i];
      end else if (cnt[i] != CNT_MAX) begin
        cnt_next[i] = cnt_inc[i][CNT_W-1:0];
      end
    end
  end

  // Pending bits are set from the registered edge pulses, and a set in the
  // same cycle as a clear survives the clear.
  always_comb begin
    pend_next = (pend_o & ~{NCH{irq_clr_i}}) | ((rise_o | fall_o) & irq_mask_i);
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      sync1   <= '0;
      sync2   <= '0;
      level_o <= '0;
      rise_o  <= '0;
      fall_o  <= '0;
      pend_o  <= '0;
      irq_o   <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1   <= pad_x_i;
      sync2   <= sync1;
      level_o <= level_next;
      rise_o  <= rise_next;
      fall_o  <= fall_next;
      pend_o  <= pend_next;
      irq_o   <= |pend_next;
      for (int i = 0; i < NCH; i++) begin
        cnt[i] <= cnt_next[i];
      end
    end
  end

`ifdef PAD_FILT_EVTCNT_EN
  logic [15:0] rise_pop;
  logic [16:0] evt_sum;

  // Number of channels rising this cycle, added with saturation at 0xFFFF.
  always_comb begin
    rise_pop = '0;
    for (int i = 0; i < NCH; i++) begin
      rise_pop = rise_pop + {15'd0, rise_o[i]};
    end
    evt_sum = {1'b0, evt_cnt_o} + {1'b0, rise_pop};
  end

  // A clear drops any increment arriving in the same cycle.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      evt_cnt_o <= '0;
    end else if (evt_clr_i) begin
      evt_cnt_o <= '0;
    end else if (evt_sum[16]) begin
      evt_cnt_o <= 16'hFFFF;
    end else begin
      evt_cnt_o <= evt_sum[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_pad_input_filter.sv
// tb_pad_input_filter
//
// Directed bench for pad_input_filter. A table of per-cycle vectors covers the
// debounce, glitch rejection and bypass behaviour; hand-written sequences
// cover the pending set/clear race, mid-count reset and, when
// PAD_FILT_EVTCNT_EN is defined, the event counter.

module tb_pad_input_filter;

  localparam int NCH   = 4;
  localparam int CNT_W = 8;

  logic             wb_clk_i = 1'b0;
  logic             wb_rst_i;
  logic [NCH-1:0]   pad_x_i;
  logic             filt_en_i;
  logic [CNT_W-1:0] db_thresh_i;
  logic [NCH-1:0]   irq_mask_i;
  logic             irq_clr_i;
  logic [NCH-1:0]   level_o;
  logic [NCH-1:0]   rise_o;
  logic [NCH-1:0]   fall_o;
  logic [NCH-1:0]   pend_o;
  logic             irq_o;
`ifdef PAD_FILT_EVTCNT_EN
  logic [15:0]      evt_cnt_o;
  logic             evt_clr_i;
`endif

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [3:0] pad;
    logic       filt_en;
    logic [7:0] thresh;
    logic [3:0] mask;
    logic       clr;
    logic [3:0] level;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] pend;
    logic       irq;
  } vec_t;

  vec_t vecs[$];

  pad_input_filter #(.NCH(NCH), .CNT_W(CNT_W)) dut (
    .wb_clk_i    (wb_clk_i),
    .wb_rst_i    (wb_rst_i),
    .pad_x_i     (pad_x_i),
    .filt_en_i   (filt_en_i),
    .db_thresh_i (db_thresh_i),
    .irq_mask_i  (irq_mask_i),
    .irq_clr_i   (irq_clr_i),
    .level_o     (level_o),
    .rise_o      (rise_o),
    .fall_o      (fall_o),
    .pend_o      (pend_o),
    .irq_o       (irq_o)
`ifdef PAD_FILT_EVTCNT_EN
    ,
    .evt_cnt_o   (evt_cnt_o),
    .evt_clr_i   (evt_clr_i)
`endif
  );

  always #5 wb_clk_i = ~wb_clk_i;

  task automatic applyStimulus(input logic [3:0] pad, input logic fen,
                               input logic [7:0] th, input logic [3:0] mask,
                               input logic clr);
    pad_x_i     = pad;
    filt_en_i   = fen;
    db_thresh_i = th;
    irq_mask_i  = mask;
    irq_clr_i   = clr;
  endtask

  // Advance one clock and settle just past the edge.
  task automatic step();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] el,
                             input logic [3:0] er, input logic [3:0] ef,
                             input logic [3:0] ep, input logic ei);
    logic [16:0] act;
    logic [16:0] exp;
    act = {level_o, rise_o, fall_o, pend_o, irq_o};
    exp = {el, er, ef, ep, ei};
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got level=%b rise=%b fall=%b pend=%b irq=%b, want level=%b rise=%b fall=%b pend=%b irq=%b",
               name, level_o, rise_o, fall_o, pend_o, irq_o, el, er, ef, ep, ei);
    end
  endtask

`ifdef PAD_FILT_EVTCNT_EN
  task automatic checkEvt(input string name, input logic [15:0] exp);
    compared++;
    if (evt_cnt_o !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got evt_cnt=%h, want %h", name, evt_cnt_o, exp);
    end
  endtask

  task automatic padStep(input logic [3:0] pad, input logic eclr);
    pad_x_i   = pad;
    evt_clr_i = eclr;
    step();
  endtask
`endif

  task automatic push(input logic [3:0] pad, input logic fen, input logic [7:0] th,
                      input logic [3:0] mask, input logic clr, input logic [3:0] el,
                      input logic [3:0] er, input logic [3:0] ef, input logic [3:0] ep,
                      input logic ei);
    vec_t v;
    v = '{pad, fen, th, mask, clr, el, er, ef, ep, ei};
    vecs.push_back(v);
  endtask

  initial begin
    bit pat [14] = '{1, 1, 0, 0, 1, 1, 0, 0, 1, 1, 0, 0, 0, 0};

    // Threshold 4 on ch0: pad sampled at row 0, level and rise at row 5,
    // pending and irq at row 6.
    for (int r = 0; r < 5; r++) push(4'b0001, 1, 8'd4, 4'b0001, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0);
    push(4'b0001, 1, 8'd4, 4'b0001, 0, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 0);
    for (int r = 0; r < 2; r++) push(4'b0001, 1, 8'd4, 4'b0001, 0, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1);
    // ch1 high for only 3 cycles: rejected.
    for (int r = 0; r < 3; r++) push(4'b0011, 1, 8'd4, 4'b0001, 0, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1);
    for (int r = 0; r < 4; r++) push(4'b0001, 1, 8'd4, 4'b0001, 0, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1);
    // ch1 held: full 4-cycle wait proves the count restarted from 0.
    for (int r = 0; r < 5; r++) push(4'b0011, 1, 8'd4, 4'b0001, 0, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1);
    push(4'b0011, 1, 8'd4, 4'b0001, 0, 4'b0011, 4'b0010, 4'b0000, 4'b0001, 1);
    push(4'b0011, 1, 8'd4, 4'b0001, 0, 4'b0011, 4'b0000, 4'b0000, 4'b0001, 1);
    push(4'b0011, 1, 8'd4, 4'b0001, 1, 4'b0011, 4'b0000, 4'b0000, 4'b0000, 0);
    push(4'b0011, 1, 8'd4, 4'b0001, 0, 4'b0011, 4'b0000, 4'b0000, 4'b0000, 0);

    // Bypass with a large threshold: ch2 follows its pad 2 cycles later.
    for (int j = 0; j < 14; j++) begin
      logic l2;
      logic p3;
      l2 = (j >= 2) ? pat[j-2] : 1'b0;
      p3 = (j >= 3) ? pat[j-3] : 1'b0;
      push({1'b0, pat[j], 2'b11}, 0, 8'd200, 4'b0000, 0,
           {1'b0, l2, 2'b11}, {1'b0, l2 & ~p3, 2'b00}, {1'b0, ~l2 & p3, 2'b00},
           4'b0000, 0);
    end

    wb_rst_i = 1'b1;
    applyStimulus(4'b0000, 1, 8'd4, 4'b0001, 0);
`ifdef PAD_FILT_EVTCNT_EN
    evt_clr_i = 1'b0;
`endif
    step();
    step();
    checkOutput("reset", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0);
`ifdef PAD_FILT_EVTCNT_EN
    checkEvt("reset_evt", 16'h0000);
`endif
    wb_rst_i = 1'b0;

    foreach (vecs[k]) begin
      applyStimulus(vecs[k].pad, vecs[k].filt_en, vecs[k].thresh, vecs[k].mask, vecs[k].clr);
      step();
      checkOutput($sformatf("vec%0d", k), vecs[k].level, vecs[k].rise, vecs[k].fall,
                  vecs[k].pend, vecs[k].irq);
    end

    // ch0 fall latches pending, then a ch3 rise pulse coincides with the clear.
    applyStimulus(4'b0010, 0, 8'd4, 4'b1001, 0);
    step();
    checkOutput("race_a0", 4'b0011, 4'b0000, 4'b0000, 4'b0000, 0);
    applyStimulus(4'b1010, 0, 8'd4, 4'b1001, 0);
    step();
    checkOutput("race_a1", 4'b0011, 4'b0000, 4'b0000, 4'b0000, 0);
    step();
    checkOutput("race_a2", 4'b0010, 4'b0000, 4'b0001, 4'b0000, 0);
    step();
    checkOutput("race_a3", 4'b1010, 4'b1000, 4'b0000, 4'b0001, 1);
    applyStimulus(4'b1010, 0, 8'd4, 4'b1001, 1);
    step();
    checkOutput("clr_vs_set", 4'b1010, 4'b0000, 4'b0000, 4'b1000, 1);
    applyStimulus(4'b1010, 0, 8'd4, 4'b1001, 0);
    step();
    checkOutput("pend_hold", 4'b1010, 4'b0000, 4'b0000, 4'b1000, 1);
    applyStimulus(4'b1010, 0, 8'd4, 4'b0000, 0);
    step();
    checkOutput("mask_keeps_pend", 4'b1010, 4'b0000, 4'b0000, 4'b1000, 1);

    // Pads all high, reset lands mid-count, then a fresh rise at 2+T.
    applyStimulus(4'b1111, 1, 8'd3, 4'b1001, 0);
    step();
    step();
    checkOutput("pre_reset", 4'b1010, 4'b0000, 4'b0000, 4'b1000, 1);
    wb_rst_i = 1'b1;
    for (int r = 0; r < 3; r++) begin
      step();
      checkOutput($sformatf("in_reset%0d", r), 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0);
    end
    wb_rst_i = 1'b0;
    for (int r = 1; r <= 4; r++) begin
      step();
      checkOutput($sformatf("post_reset%0d", r), 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0);
    end
    step();
    checkOutput("post_reset5", 4'b1111, 4'b1111, 4'b0000, 4'b0000, 0);
    step();
    checkOutput("post_reset6", 4'b1111, 4'b0000, 4'b0000, 4'b1001, 1);

`ifdef PAD_FILT_EVTCNT_EN
    applyStimulus(4'b0000, 0, 8'd3, 4'b0000, 1);
    for (int r = 0; r < 4; r++) padStep(4'b0000, 1'b0);
    padStep(4'b0000, 1'b1);
    padStep(4'b0000, 1'b0);
    checkEvt("evt_cleared", 16'h0000);
    for (int r = 0; r < 4; r++) padStep(4'b0111, 1'b0);
    checkEvt("evt_three_rises", 16'h0003);
    for (int r = 0; r < 3; r++) padStep(4'b0000, 1'b0);
    padStep(4'b0000, 1'b1);
    padStep(4'b0000, 1'b0);
    checkEvt("evt_cleared2", 16'h0000);
    for (int r = 0; r < 16383; r++) begin
      padStep(4'b1111, 1'b0);
      padStep(4'b0000, 1'b0);
    end
    for (int r = 0; r < 4; r++) padStep(4'b0000, 1'b0);
    checkEvt("evt_fffc", 16'hFFFC);
    padStep(4'b0011, 1'b0);
    for (int r = 0; r < 4; r++) padStep(4'b0000, 1'b0);
    checkEvt("evt_fffe", 16'hFFFE);
    padStep(4'b0111, 1'b0);
    for (int r = 0; r < 4; r++) padStep(4'b0000, 1'b0);
    checkEvt("evt_saturate", 16'hFFFF);
    padStep(4'b0001, 1'b0);
    padStep(4'b0001, 1'b0);
    padStep(4'b0001, 1'b0);
    padStep(4'b0001, 1'b1);
    checkEvt("evt_clr_vs_rise", 16'h0000);
    padStep(4'b0001, 1'b0);
    checkEvt("evt_after_clr", 16'h0000);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
